// File: rtl/regs_bank.sv
// Register bank behind the AXI-Lite register bridge: ID, scratch, control, cycle counter, stream FIFO.
// Read/write status registered one cycle after the strobe; stream stalls (in_tready=0) only when the FIFO is full.
module regs_bank #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hDEC0_0001,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   reg_rd_addr,
  input  logic                    reg_rd_en,
  output logic [DATA_WIDTH-1:0]   reg_rd_data,
  output logic                    reg_rd_okay,
  input  logic [ADDR_WIDTH-1:0]   reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]   reg_wr_data,
  input  logic [DATA_WIDTH/8-1:0] reg_wr_strb,
  input  logic                    reg_wr_en,
  output logic                    reg_wr_okay,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic                    in_tvalid,
  output logic                    in_tready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  localparam logic [ADDR_WIDTH-1:0] A_ID      = 'h00;
  localparam logic [ADDR_WIDTH-1:0] A_SCRATCH = 'h04;
  localparam logic [ADDR_WIDTH-1:0] A_CTRL    = 'h08;
  localparam logic [ADDR_WIDTH-1:0] A_CNT     = 'h0C;
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = 'h10;
  localparam logic [ADDR_WIDTH-1:0] A_FDATA   = 'h14;
  localparam logic [ADDR_WIDTH-1:0] A_FLEVEL  = 'h18;

  logic [DATA_WIDTH-1:0] scratch;
  logic                  cnt_en;
  logic [DATA_WIDTH-1:0] cnt;
  logic                  ovf;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      level;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;

  logic [DATA_WIDTH-1:0] rd_data_nxt;
  logic                  rd_okay_nxt;

  logic                  wr_scratch;
  logic                  wr_ctrl;
  logic                  wr_status;
  logic                  wr_hit;
  logic                  cnt_clr;
  logic                  ovf_set;
  logic                  ovf_w1c;

  // Full when the pointers index the same slot but differ in the wrap bit.
  assign level      = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign in_tready  = !fifo_full;
  assign push       = in_tvalid && in_tready;

  always_comb begin
    rd_data_nxt = '0;
    rd_okay_nxt = 1'b0;
    pop         = 1'b0;
    case (reg_rd_addr)
      A_ID: begin
        rd_data_nxt = ID_VALUE;
        rd_okay_nxt = 1'b1;
      end
      A_SCRATCH: begin
        rd_data_nxt = scratch;
        rd_okay_nxt = 1'b1;
      end
      A_CTRL: begin
        rd_data_nxt = {{(DATA_WIDTH-1){1'b0}}, cnt_en};
        rd_okay_nxt = 1'b1;
      end
      A_CNT: begin
        rd_data_nxt = cnt;
        rd_okay_nxt = 1'b1;
      end
      A_STATUS: begin
        rd_data_nxt = {{(DATA_WIDTH-1){1'b0}}, ovf};
        rd_okay_nxt = 1'b1;
      end
      A_FDATA: begin
        if (!fifo_empty) begin
          rd_data_nxt = mem[rd_ptr[IDX_W-1:0]];
          rd_okay_nxt = 1'b1;
          pop         = reg_rd_en;
        end
      end
      A_FLEVEL: begin
        rd_data_nxt = DATA_WIDTH'(level);
        rd_okay_nxt = 1'b1;
      end
      default: begin
        rd_data_nxt = '0;
        rd_okay_nxt = 1'b0;
      end
    endcase
  end

  assign wr_scratch = reg_wr_en && (reg_wr_addr == A_SCRATCH);
  assign wr_ctrl    = reg_wr_en && (reg_wr_addr == A_CTRL);
  assign wr_status  = reg_wr_en && (reg_wr_addr == A_STATUS);
  assign wr_hit     = (reg_wr_addr == A_SCRATCH) || (reg_wr_addr == A_CTRL) ||
                      (reg_wr_addr == A_STATUS);

  // CTRL[1] is a pulse: it clears the counter at this edge and is never stored.
  assign cnt_clr = wr_ctrl && reg_wr_strb[0] && reg_wr_data[1];
  assign ovf_set = !cnt_clr && cnt_en && (&cnt);
  assign ovf_w1c = wr_status && reg_wr_strb[0] && reg_wr_data[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_rd_data <= '0;
      reg_rd_okay <= 1'b0;
      reg_wr_okay <= 1'b0;
    end else begin
      if (reg_rd_en) begin
        reg_rd_data <= rd_data_nxt;
        reg_rd_okay <= rd_okay_nxt;
      end
      if (reg_wr_en) begin
        reg_wr_okay <= wr_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
    end else if (wr_scratch) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (reg_wr_strb[i]) begin
          scratch[8*i +: 8] <= reg_wr_data[8*i +: 8];
        end
      end
    end
  end

  // Counter update uses the enable held before any same-cycle CTRL write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_en <= 1'b0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ctrl && reg_wr_strb[0]) begin
        cnt_en <= reg_wr_data[0];
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_en) begin
        cnt <= cnt + 1'b1;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_w1c) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]] <= in_tdata;
    end
  end

endmodule
